// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit_pkg
// Brief    : Shared access-size encodings, FSM state type and alignment helper
//            for the load/store unit.
// Revision : 1.0 - initial release
// ============================================================================
package load_store_unit_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_DONE = 2'b10
  } lsu_state_e;

  // Reserved size 2'b11 falls into the word rule.
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = lo[0];
      default: is_misaligned = (lo != 2'b00);
    endcase
  endfunction

endpackage : load_store_unit_pkg
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_lane_align
// Brief    : Combinational byte-lane steering for stores and extraction plus
//            sign/zero extension for loads.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  adr_lo,
  input  logic        load_signed,
  input  logic [31:0] write_data,
  input  logic [31:0] bus_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [31:0] w_shifted;

  assign w_shifted = bus_rdata >> {adr_lo, 3'b000};

  always_comb begin
    be        = 4'b1111;
    wdata     = write_data;
    load_data = w_shifted;
    case (size)
      SZ_BYTE: begin
        be        = 4'b0001 << adr_lo;
        wdata     = {4{write_data[7:0]}};
        load_data = {{24{load_signed & w_shifted[7]}}, w_shifted[7:0]};
      end
      SZ_HALF: begin
        be        = adr_lo[1] ? 4'b1100 : 4'b0011;
        wdata     = {2{write_data[15:0]}};
        load_data = {{16{load_signed & w_shifted[15]}}, w_shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule : lsu_lane_align
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : MEM-stage load/store unit: stalls the pipeline while a single
//            registered data-memory transaction completes (IDLE/REQ/DONE).
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [1:0]        size,
  input  logic              load_signed,
  input  logic [ADDR_W-1:0] adr,
  input  logic [31:0]       write_data,
  output logic [31:0]       read_data,
  output logic              stall,
  output logic              misalign,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_adr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_be,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata
);

  lsu_state_e r_state;
  lsu_state_e w_state_nxt;

  logic              r_bus_req;
  logic              r_bus_we;
  logic [ADDR_W-1:0] r_bus_adr;
  logic [31:0]       r_bus_wdata;
  logic [3:0]        r_bus_be;
  logic [31:0]       r_read_data;
  logic [1:0]        r_size;
  logic [1:0]        r_adr_lo;
  logic              r_signed;

  logic              w_access;
  logic              w_misaligned;
  logic              w_issue;
  logic              w_capture;
  logic [1:0]        w_al_size;
  logic [1:0]        w_al_lo;
  logic              w_al_signed;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [31:0]       w_load;

  assign w_access     = mem_read | mem_write;
  assign w_misaligned = is_misaligned(size, adr[1:0]);

  // Live inputs steer the issue; the captured attributes drive load extraction.
  assign w_al_size   = (r_state == ST_IDLE) ? size        : r_size;
  assign w_al_lo     = (r_state == ST_IDLE) ? adr[1:0]    : r_adr_lo;
  assign w_al_signed = (r_state == ST_IDLE) ? load_signed : r_signed;

  lsu_lane_align u_lane_align (
    .size        (w_al_size),
    .adr_lo      (w_al_lo),
    .load_signed (w_al_signed),
    .write_data  (write_data),
    .bus_rdata   (bus_rdata),
    .be          (w_be),
    .wdata       (w_wdata),
    .load_data   (w_load)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    stall       = 1'b0;
    misalign    = 1'b0;
    w_issue     = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_access) begin
          if (w_misaligned) begin
            misalign = rst;
          end else begin
            stall       = 1'b1;
            w_issue     = 1'b1;
            w_state_nxt = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        stall = 1'b1;
        if (bus_ack) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_adr   <= '0;
      r_bus_wdata <= '0;
      r_bus_be    <= '0;
      r_read_data <= '0;
      r_size      <= SZ_BYTE;
      r_adr_lo    <= 2'b00;
      r_signed    <= 1'b0;
    end else begin
      if (w_issue) begin
        r_bus_req   <= 1'b1;
        r_bus_we    <= mem_write;
        r_bus_adr   <= {adr[ADDR_W-1:2], 2'b00};
        r_bus_be    <= w_be;
        r_bus_wdata <= mem_write ? w_wdata : 32'h0;
        r_size      <= size;
        r_adr_lo    <= adr[1:0];
        r_signed    <= load_signed;
      end else if (w_capture) begin
        r_bus_req <= 1'b0;
      end
      // Only a completed load leaves a nonzero value, and only for the DONE cycle.
      r_read_data <= (w_capture && !r_bus_we) ? w_load : 32'h0;
    end
  end

  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_adr   = r_bus_adr;
  assign bus_wdata = r_bus_wdata;
  assign bus_be    = r_bus_be;
  assign read_data = r_read_data;

endmodule : load_store_unit
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Brief    : Randomized scoreboard bench for load_store_unit with a memory
//            responder and a byte-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write, load_signed;
  logic [1:0]  size;
  logic [31:0] adr, write_data;
  logic [31:0] read_data;
  logic        stall, misalign, bus_req, bus_we;
  logic [31:0] bus_adr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .size(size), .load_signed(load_signed), .adr(adr), .write_data(write_data),
    .read_data(read_data), .stall(stall), .misalign(misalign),
    .bus_req(bus_req), .bus_we(bus_we), .bus_adr(bus_adr),
    .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata)
  );

  typedef struct {
    bit          mis;
    bit          we;
    logic [31:0] adr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          stalls;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  bit          mon_en = 1'b0;
  bit          resp_en = 1'b0;
  int          ack_lat = 1;
  logic [31:0] mem_rdata = 32'h0;
  logic        force_ack = 1'b0;
  logic [31:0] force_rdata = 32'h0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: an access touches n bytes starting at byte offset off.
  function automatic exp_t model(input bit wr, input logic [1:0] sz, input bit sgn,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input logic [31:0] rdw, input int lat);
    exp_t        e;
    int          n, off;
    logic [31:0] val, mask;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    off = int'(a[1:0]);
    e.mis = (off % n) != 0;
    e.we  = wr;
    e.adr = {a[31:2], 2'b00};
    e.be  = 4'b0000;
    for (int k = 0; k < 4; k++) if (k >= off && k < off + n) e.be[k] = 1'b1;
    e.wdata = 32'h0;
    for (int k = 0; k < 4; k++) e.wdata[8*k +: 8] = wd[8*(k % n) +: 8];
    mask = (n == 4) ? 32'hFFFF_FFFF : (32'd1 << (8*n)) - 32'd1;
    val  = (rdw >> (8*off)) & mask;
    if (sgn && n < 4 && val[8*n-1]) val = val | ~mask;
    e.rdata  = wr ? 32'h0 : val;
    e.stalls = 1 + lat;
    return e;
  endfunction

  task automatic do_access(input bit rd, input bit wr, input logic [1:0] sz, input bit sgn,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rdw, input int lat);
    exp_t e;
    int   n;
    bit   done;
    e = model(wr, sz, sgn, a, wd, rdw, lat);
    n = 0;
    done = 1'b0;
    @(posedge clk); #1;
    ack_lat = lat; mem_rdata = rdw;
    mem_read = rd; mem_write = wr; size = sz; load_signed = sgn; adr = a; write_data = wd;
    exp_q.push_back(e);
    if (e.mis) begin
      @(posedge clk); #1;
    end else begin
      while (!done && n < 60) begin
        @(posedge clk); #1;
        n++;
        if (!stall) done = 1'b1;
      end
      if (!done) begin
        checks++; errors++;
        $display("FAIL access_timeout: stall still 1 after %0d cycles, required 0", n);
      end
    end
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  // Memory responder: acks on the ack_lat-th REQ cycle, junk acks while idle.
  initial begin
    int cnt;
    cnt = 0;
    bus_ack = 1'b0; bus_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!resp_en) begin
        cnt = 0;
        bus_ack = force_ack; bus_rdata = force_rdata;
      end else if (bus_req) begin
        cnt++;
        bus_ack   = (cnt == ack_lat);
        bus_rdata = (cnt == ack_lat) ? mem_rdata : $urandom;
      end else begin
        cnt = 0;
        bus_ack   = ($urandom_range(0, 3) == 0);
        bus_rdata = $urandom;
      end
    end
  end

  // Monitor: compares DUT events against the head of the scoreboard queue.
  initial begin
    bit   prev_req;
    int   run;
    exp_t snap, e;
    prev_req = 1'b0; run = 0;
    forever begin
      @(negedge clk);
      if (mon_en && rst) begin
        if (misalign) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL misalign_unexpected: got misalign=1 with empty queue, required 0");
          end else begin
            e = exp_q.pop_front();
            check32("misalign_expected", 32'(misalign), 32'(e.mis));
            check32("misalign_stall", 32'(stall), 32'h0);
          end
        end
        if (bus_req && !prev_req) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL issue_unexpected: got bus_req=1 with empty queue, required 0");
          end else begin
            snap = exp_q[0];
            check32("issue_not_misaligned", 32'(snap.mis), 32'h0);
            check32("issue_adr", bus_adr, snap.adr);
            check32("issue_we", 32'(bus_we), 32'(snap.we));
            check32("issue_be", 32'(bus_be), 32'(snap.be));
            if (snap.we) check32("issue_wdata", bus_wdata, snap.wdata);
          end
        end else if (bus_req && prev_req) begin
          check32("hold_adr", bus_adr, snap.adr);
          check32("hold_we", 32'(bus_we), 32'(snap.we));
          check32("hold_be", 32'(bus_be), 32'(snap.be));
        end
        if (bus_req) check32("rdata_in_req", read_data, 32'h0);
        if (!bus_req && prev_req) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL done_unexpected: got completion with empty queue");
          end else begin
            e = exp_q.pop_front();
            check32("done_rdata", read_data, e.rdata);
            check32("done_stall", 32'(stall), 32'h0);
            check32("stall_cycles", 32'(run), 32'(e.stalls));
          end
        end else if (!bus_req && !misalign) begin
          check32("rdata_idle", read_data, 32'h0);
        end
        prev_req = bus_req;
        run = stall ? run + 1 : 0;
      end else begin
        prev_req = bus_req;
        run = 0;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, w;
    rst = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; size = 2'b00; load_signed = 1'b0;
    adr = 32'h0; write_data = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check32("reset_bus_req", 32'(bus_req), 32'h0);
    check32("reset_bus_we", 32'(bus_we), 32'h0);
    check32("reset_bus_adr", bus_adr, 32'h0);
    check32("reset_bus_wdata", bus_wdata, 32'h0);
    check32("reset_bus_be", 32'(bus_be), 32'h0);
    check32("reset_read_data", read_data, 32'h0);
    mem_read = 1'b1; size = 2'b10; adr = 32'h10; #1;
    check32("reset_stall_aligned", 32'(stall), 32'h1);
    adr = 32'h06; #1;
    check32("reset_misalign_held", 32'(misalign), 32'h0);
    check32("reset_stall_misaligned", 32'(stall), 32'h0);
    mem_read = 1'b0; adr = 32'h0;
    @(posedge clk); #1;
    rst = 1'b1; mon_en = 1'b1; resp_en = 1'b1;

    do_access(1, 0, 2'b10, 0, 32'h10, 32'h0, 32'hDEADBEEF, 1);
    do_access(1, 0, 2'b00, 1, 32'h13, 32'h0, 32'h80FF0000, 1);
    do_access(1, 0, 2'b00, 0, 32'h13, 32'h0, 32'h80FF0000, 2);
    do_access(0, 1, 2'b01, 0, 32'h22, 32'h1234ABCD, 32'h0, 1);
    do_access(1, 0, 2'b10, 0, 32'h06, 32'h0, 32'h0, 1);
    do_access(1, 0, 2'b01, 1, 32'h05, 32'h0, 32'h0, 1);
    do_access(1, 0, 2'b10, 0, 32'h44, 32'h0, 32'hCAFEF00D, 5);
    do_access(1, 0, 2'b01, 1, 32'h52, 32'h0, 32'h9ABC1234, 3);
    do_access(1, 1, 2'b00, 1, 32'h31, 32'h000000A5, 32'hFFFFFFFF, 1);
    do_access(1, 0, 2'b11, 0, 32'h60, 32'h0, 32'h01020304, 2);
    do_access(0, 1, 2'b11, 0, 32'h61, 32'h55AA55AA, 32'h0, 1);

    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(1, 3);
      w = $urandom_range(0, 2);
      do_access(r[0], r[1], 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                $urandom, $urandom, $urandom, $urandom_range(1, 4));
      repeat (w) @(posedge clk);
    end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    check32("queue_drained", 32'(exp_q.size()), 32'h0);

    // Reset in the second REQ cycle, then a stale ack.
    mon_en = 1'b0; resp_en = 1'b0;
    @(posedge clk); #1;
    mem_read = 1'b1; mem_write = 1'b0; size = 2'b10; adr = 32'h40; load_signed = 1'b0;
    @(posedge clk); #1;
    check32("rst_test_req_up", 32'(bus_req), 32'h1);
    @(posedge clk); #1;
    rst = 1'b0; #1;
    check32("rst_async_bus_req", 32'(bus_req), 32'h0);
    check32("rst_async_bus_adr", bus_adr, 32'h0);
    check32("rst_async_bus_be", 32'(bus_be), 32'h0);
    check32("rst_async_read_data", read_data, 32'h0);
    mem_read = 1'b0; #1;
    check32("rst_fsm_idle_stall", 32'(stall), 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    force_ack = 1'b1; force_rdata = 32'h12345678;
    @(posedge clk); @(posedge clk); #1;
    force_ack = 1'b0;
    check32("stale_ack_bus_req", 32'(bus_req), 32'h0);
    check32("stale_ack_read_data", read_data, 32'h0);
    check32("stale_ack_stall", 32'(stall), 32'h0);
    @(posedge clk); #1;
    check32("stale_ack_read_data_later", read_data, 32'h0);

    mon_en = 1'b1; resp_en = 1'b1;
    do_access(1, 0, 2'b01, 0, 32'h76, 32'h0, 32'hF00D0000, 2);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    check32("final_queue_drained", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_load_store_unit
`default_nettype wire

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ADDR_W, default 32, address width for adr and bus_adr.
REQ-002 Port clk input 1: single clock; all state updates on its rising edge.
REQ-003 Port rst input 1: reset, asynchronous and active-low.
REQ-004 Port mem_read input 1: MEM-stage load request.
REQ-005 Port mem_write input 1: MEM-stage store request.
REQ-006 Port size input 2: access size; 00 byte, 01 half, 10 word, 11 reserved (treated as word).
REQ-007 Port load_signed input 1: 1 sign-extends byte/half loads, 0 zero-extends.
REQ-008 Port adr input ADDR_W: byte address from the ALU.
REQ-009 Port write_data input 32: store data, right-justified.
REQ-010 Port read_data output 32: load result, valid only in DONE, else 0.
REQ-011 Port stall output 1: freezes PC and pipeline registers while high.
REQ-012 Port misalign output 1: one-cycle flag for a rejected misaligned access.
REQ-013 Port bus_req output 1: registered request to the data memory.
REQ-014 Port bus_we output 1: 1 write, 0 read.
REQ-015 Port bus_adr output ADDR_W: word-aligned address (adr with [1:0]=00).
REQ-016 Port bus_wdata output 32: lane-steered store data.
REQ-017 Port bus_be output 4: byte enables; bit k selects bits 8k+7:8k.
REQ-018 Port bus_ack input 1: single-cycle completion strobe from memory.
REQ-019 Port bus_rdata input 32: read word, valid in the bus_ack cycle.

Function
REQ-020 FSM states: IDLE, REQ, DONE.
REQ-021 IDLE: an aligned access (mem_read|mem_write) drives stall=1 combinationally and moves to REQ at the next edge; bus_adr, bus_we, bus_be and bus_wdata are registered at the same edge.
REQ-022 REQ: bus_req=1 and stall=1; bus outputs stay constant until bus_ack.
REQ-023 REQ with bus_ack: capture the extracted load into read_data, move to DONE, and drop bus_req at the same edge.
REQ-024 DONE: stall=0 for exactly one cycle, then unconditional return to IDLE; no new request is issued from DONE.
REQ-025 A zero-wait memory (ack in the first REQ cycle) gives a 3-cycle access: 2 stall cycles plus 1 DONE cycle.
REQ-026 mem_read and mem_write both high: the store wins and no load is performed.
REQ-027 Misaligned access (half with adr[0]=1; word with adr[1:0]!=00): misalign=1 and stall=0 in that IDLE cycle, no bus transaction, read_data=0, FSM stays in IDLE.
REQ-028 Little-endian byte stores: bus_be=0001<<adr[1:0]; write_data[7:0] is replicated into all four lanes.
REQ-029 Halfword stores: bus_be=0011 when adr[1]=0, 1100 when adr[1]=1; write_data[15:0] is replicated into both halves.
REQ-030 Word stores: bus_be=1111.
REQ-031 Loads: bus_be follows the same patterns as stores; data is shifted right by 8*adr[1:0], then extended to 32 bits per load_signed.
REQ-032 Stores reaching DONE: read_data=0.
REQ-033 bus_ack is ignored in IDLE and DONE.
REQ-034 bus_rdata is sampled only on an edge where bus_req&bus_ack&~bus_we.

Reset
REQ-035 rst low forces, immediately: FSM=IDLE; bus_req=0, bus_we=0, bus_adr=0, bus_wdata=0, bus_be=0, read_data=0, misalign=0; stall depends only on inputs.
REQ-036 Reset during REQ abandons the transaction; a later bus_ack for it is ignored.

Structure
REQ-037 A shared package holds the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state enum.
REQ-038 Lane steering and load extraction are a combinational sub-module, lsu_lane_align, instantiated once.

Verification
REQ-039 Word load, adr=0x10, bus_rdata=0xDEADBEEF, ack in the 1st REQ cycle -> stall high for 2 cycles; DONE read_data=0xDEADBEEF; bus_be=1111; bus_adr=0x10.
REQ-040 Byte load, adr=0x13, load_signed=1, bus_rdata=0x80FF0000 -> bus_be=1000, read_data=0xFFFFFF80; with load_signed=0 -> 0x00000080.
REQ-041 Half store, adr=0x22, write_data=0x1234ABCD -> bus_be=1100, bus_wdata=0xABCDABCD, bus_we=1, bus_adr=0x20, DONE read_data=0.
REQ-042 Word load, adr=0x06 -> misalign=1 for 1 cycle, stall=0, bus_req never rises.
REQ-043 Load with ack delayed 5 cycles -> stall high for 6 cycles, bus outputs stable, result visible only in DONE.
REQ-044 rst pulsed low in the 2nd REQ cycle, then ack -> bus_req=0 at once, FSM in IDLE, read_data stays 0.
